dmem_port_arbiter: RTL and testbench

//  Shares the byte-wide data memory between two word requesters: port 0 (CPU load/store) and port 1 (aux/loader).

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/dmem_arb_pick.sv | 41 ++++
 rtl/dmem_port_arbiter.sv | 225 ++++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory port arbiter: FSM state encoding,
// requester port identifiers, byte width and a small port helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int BYTE_W = 8;

    // Identifier of the port that is not 'port'.
    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
// Two-way request picker for the data-memory arbiter.
// Configuration macro: DMEM_ARB_RR_EN
//   defined   : on contention the port named by 'ptr' wins (round-robin pointer
//               is maintained by the parent); the 'ptr' port exists.
//   undefined : fixed priority, port 0 (CPU) wins contention; no 'ptr' port.
// Ports:
//   req0, req1 : request levels from port 0 / port 1
//   ptr        : preferred port on contention (round-robin build only)
//   gnt_valid  : at least one request present
//   gnt_id     : winning port (PORT_CPU / PORT_AUX)
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
`ifdef DMEM_ARB_RR_EN
    input  logic ptr,
`endif
    output logic gnt_valid,
    output logic gnt_id
);

    // Winner selection; a lone request is always granted.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = PORT_CPU;
        if (req0 && req1) begin
`ifdef DMEM_ARB_RR_EN
            gnt_id = ptr;
`else
            gnt_id = PORT_CPU;
`endif
        end else if (req1) begin
            gnt_id = PORT_AUX;
        end else begin
            gnt_id = PORT_CPU;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares a byte-wide memory array between two 16-bit word requesters (port 0:
// CPU load/store, port 1: aux/loader). Each word access takes two big-endian
// byte cycles (high byte at addr, low byte at addr+1, wrapping in ADDR_W bits),
// followed by a one-cycle ack. The array read is combinational.
// Configuration macro: DMEM_ARB_RR_EN (round-robin on contention when
// defined, fixed priority to port 0 otherwise).
// Ports:
//   Clock, Reset        : clock, synchronous active-high reset
//   req/we/addr/wdata N : level request held until ack, write flag, byte
//                         address (only [ADDR_W-1:0] used), write word
//   ackN, rdataN        : one-cycle completion pulse, read word (held)
//   busy                : arbiter not idle
//   mem_addr/we/wdata   : byte interface to the array
//   mem_rdata           : combinational byte read data from the array
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [15:0]       addr0,
    input  logic [15:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t              state_r;
    state_t              state_nx_s;
    logic                busy_r;

    logic                gnt_valid_s;
    logic                gnt_id_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    logic                gnt_id_r;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [BYTE_W-1:0]   hi_byte_r;

    logic [ADDR_W-1:0]   mem_addr_r;
    logic                mem_we_r;
    logic [BYTE_W-1:0]   mem_wdata_r;

    logic                ack0_r;
    logic                ack1_r;
    logic [DATA_W-1:0]   rdata0_r;
    logic [DATA_W-1:0]   rdata1_r;

    // Upper address bits are outside the array and deliberately ignored.
    logic                unused_addr_s;
    assign unused_addr_s = ^{addr0[15:ADDR_W], addr1[15:ADDR_W]};

`ifdef DMEM_ARB_RR_EN
    logic                ptr_r;
`endif

    dmem_arb_pick u_pick (
        .req0      (req0),
        .req1      (req1),
`ifdef DMEM_ARB_RR_EN
        .ptr       (ptr_r),
`endif
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    // Next-state logic: IDLE -> HI -> LO -> ACK -> IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_nx_s = ST_HI;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_HI:   state_nx_s = ST_LO;
            ST_LO:   state_nx_s = ST_ACK;
            ST_ACK:  state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Request fields of the port the picker currently favours.
    always_comb begin
        sel_we_s    = we0;
        sel_addr_s  = addr0[ADDR_W-1:0];
        sel_wdata_s = wdata0;
        if (gnt_id_s == PORT_AUX) begin
            sel_we_s    = we1;
            sel_addr_s  = addr1[ADDR_W-1:0];
            sel_wdata_s = wdata1;
        end else begin
            sel_we_s    = we0;
            sel_addr_s  = addr0[ADDR_W-1:0];
            sel_wdata_s = wdata0;
        end
    end

    // State register and registered busy flag.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
        end
    end

    // Latch the winning request at grant so later requester changes are ignored.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            gnt_id_r <= PORT_CPU;
            we_r     <= 1'b0;
            addr_r   <= {ADDR_W{1'b0}};
            wdata_r  <= {DATA_W{1'b0}};
        end else if ((state_r == ST_IDLE) && gnt_valid_s) begin
            gnt_id_r <= gnt_id_s;
            we_r     <= sel_we_s;
            addr_r   <= sel_addr_s;
            wdata_r  <= sel_wdata_s;
        end
    end

    // Byte interface registers, loaded one cycle ahead of the byte they serve;
    // the high read byte is captured at the end of HI.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_we_r    <= 1'b0;
            mem_wdata_r <= 8'h00;
            hi_byte_r   <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt_valid_s) begin
                        mem_addr_r  <= sel_addr_s;
                        mem_we_r    <= sel_we_s;
                        mem_wdata_r <= sel_wdata_s[DATA_W-1:BYTE_W];
                    end else begin
                        mem_we_r    <= 1'b0;
                    end
                end
                ST_HI: begin
                    hi_byte_r   <= mem_rdata;
                    mem_addr_r  <= addr_r + ADDR_W'(1);
                    mem_we_r    <= we_r;
                    mem_wdata_r <= wdata_r[BYTE_W-1:0];
                end
                ST_LO:   mem_we_r <= 1'b0;
                ST_ACK:  mem_we_r <= 1'b0;
                default: mem_we_r <= 1'b0;
            endcase
        end
    end

    // Completion: ack pulse and read word for the granted port on entry to ACK.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            rdata0_r <= {DATA_W{1'b0}};
            rdata1_r <= {DATA_W{1'b0}};
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
            if (state_r == ST_LO) begin
                if (gnt_id_r == PORT_AUX) begin
                    ack1_r <= 1'b1;
                    if (!we_r) begin
                        rdata1_r <= {hi_byte_r, mem_rdata};
                    end
                end else begin
                    ack0_r <= 1'b1;
                    if (!we_r) begin
                        rdata0_r <= {hi_byte_r, mem_rdata};
                    end
                end
            end
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Round-robin pointer: after a grant the other port is preferred.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_r <= PORT_CPU;
        end else if ((state_r == ST_IDLE) && gnt_valid_s) begin
            ptr_r <= other_port(gnt_id_s);
        end
    end
`endif

    // Reset gates the write strobe immediately so an aborted write stops at once.
    assign mem_we    = mem_we_r & ~Reset;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign ack0      = ack0_r;
    assign ack1      = ack1_r;
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter
// Self-checking bench for dmem_port_arbiter with a 128-byte array model and a
// word-level reference (byte array, per-port read words, arbitration pointer).
module tb_dmem_port_arbiter;

    logic        Clock;
    logic        Reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, busy, mem_we;
    logic [15:0] rdata0, rdata1;
    logic [6:0]  mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  tb_mem  [0:127];
    logic [7:0]  ref_mem [0:127];
    logic [15:0] ref_rdata [0:1];
    logic        model_ptr;

    int compared   = 0;
    int mismatched = 0;

    dmem_port_arbiter #(.ADDR_W(7), .DATA_W(16)) dut (
        .Clock(Clock), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Byte array: synchronous write, combinational read.
    always @(posedge Clock) if (mem_we) tb_mem[mem_addr] <= mem_wdata;
    assign mem_rdata = tb_mem[mem_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic contention_winner(input logic ptr);
`ifdef DMEM_ARB_RR_EN
        return ptr;
`else
        return 1'b0;
`endif
    endfunction

    // Apply one completed word access to the reference model.
    task automatic model_access(input logic p, input logic w, input logic [15:0] a, input logic [15:0] d);
        int b0, b1;
        b0 = a % 128;
        b1 = (a + 1) % 128;
        if (w) begin
            ref_mem[b0] = d[15:8];
            ref_mem[b1] = d[7:0];
        end else begin
            ref_rdata[p] = {ref_mem[b0], ref_mem[b1]};
        end
        model_ptr = ~p;
    endtask

    // One uncontended access with per-cycle checks of the byte interface.
    task automatic do_access(input logic p, input logic w, input logic [15:0] a, input logic [15:0] d);
        int b0, b1;
        b0 = a % 128;
        b1 = (a + 1) % 128;
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        @(negedge Clock);
        check("hi_busy", busy, 1);
        check("hi_addr", mem_addr, b0);
        check("hi_we", mem_we, w);
        if (w) check("hi_wdata", mem_wdata, d[15:8]);
        @(negedge Clock);
        check("lo_addr", mem_addr, b1);
        check("lo_we", mem_we, w);
        if (w) check("lo_wdata", mem_wdata, d[7:0]);
        @(negedge Clock);
        check("ack_id", {ack1, ack0}, p ? 2'b10 : 2'b01);
        check("ack_we", mem_we, 0);
        req0 = 1'b0; req1 = 1'b0;
        model_access(p, w, a, d);
        check("rdata0", rdata0, ref_rdata[0]);
        check("rdata1", rdata1, ref_rdata[1]);
        @(negedge Clock);
        check("idle_ack", {ack1, ack0}, 2'b00);
        check("idle_busy", busy, 0);
        check("mem_hi", tb_mem[b0], ref_mem[b0]);
        check("mem_lo", tb_mem[b1], ref_mem[b1]);
    endtask

    initial begin
        logic [15:0] d;
        int acks;
        logic seen;
        logic win;

        for (int i = 0; i < 128; i++) begin
            tb_mem[i]  = 8'($urandom);
            ref_mem[i] = tb_mem[i];
        end
        ref_rdata[0] = 16'h0000;
        ref_rdata[1] = 16'h0000;
        model_ptr = 1'b0;
        Reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
        repeat (2) @(negedge Clock);
        check("rst_ack", {ack1, ack0}, 2'b00);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        check("rst_busy", busy, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        Reset = 1'b0;
        @(negedge Clock);

        // Directed write then read-back by the other port.
        do_access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000);
        check("readback", rdata1, 16'hBEEF);
        check("rdata0_kept", rdata0, 16'h0000);

        // Address wrap and ignored upper bits.
        do_access(1'b0, 1'b1, 16'h007F, 16'h1234);
        check("wrap_hi", tb_mem[127], 8'h12);
        check("wrap_lo", tb_mem[0], 8'h34);
        do_access(1'b0, 1'b1, 16'h00FF, 16'h5678);
        check("wrapff_hi", tb_mem[127], 8'h56);
        check("wrapff_lo", tb_mem[0], 8'h78);
        do_access(1'b1, 1'b0, 16'hFF7F, 16'h0000);
        check("wrap_read", rdata1, 16'h5678);

        // Request latched at grant: changes during HI are ignored.
        d = 16'($urandom);
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = d;
        @(negedge Clock);
        addr0 = 16'h0020; wdata0 = ~d; req0 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge Clock);
            if (ack0) seen = 1'b1;
        end
        check("latch_ack", seen, 1);
        model_access(1'b0, 1'b1, 16'h0010, d);
        @(negedge Clock);
        check("latch_m10", tb_mem[16], ref_mem[16]);
        check("latch_m11", tb_mem[17], ref_mem[17]);
        check("latch_m20", tb_mem[32], ref_mem[32]);
        check("latch_m21", tb_mem[33], ref_mem[33]);

        // Contention: both held for three accesses.
        d = 16'($urandom);
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0040; wdata0 = d;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0040;
        acks = 0;
        for (int c = 0; c < 20 && acks < 3; c++) begin
            @(negedge Clock);
            if (ack0 || ack1) begin
                win = contention_winner(model_ptr);
                check("cont_gnt", {ack1, ack0}, win ? 2'b10 : 2'b01);
                if (win) model_access(1'b1, 1'b0, 16'h0040, 16'h0000);
                else     model_access(1'b0, 1'b1, 16'h0040, d);
                check("cont_rdata1", rdata1, ref_rdata[1]);
                acks++;
                if (acks == 3) begin req0 = 1'b0; req1 = 1'b0; end
            end
        end
        check("cont_count", acks, 3);
        @(negedge Clock);
        check("cont_idle", busy, 0);
        check("cont_mem", {tb_mem[64], tb_mem[65]}, {ref_mem[64], ref_mem[65]});

        // Randomized single-port accesses.
        for (int n = 0; n < 40; n++) begin
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      16'($urandom), 16'($urandom));
        end

        // Reset during the LO cycle of a write.
        d = tb_mem[49];
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0030; wdata0 = 16'hAAAA;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1; req0 = 1'b0;
        #1;
        check("rst_lo_we", mem_we, 0);
        @(negedge Clock);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ack", {ack1, ack0}, 2'b00);
        check("rst_mid_we", mem_we, 0);
        check("rst_mid_hi", tb_mem[48], 8'hAA);
        check("rst_mid_lo", tb_mem[49], d[7:0]);
        Reset = 1'b0;
        @(negedge Clock);
        check("rst_mid_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
